// File: rtl/arb_pkg.sv
// Shared FSM state encodings and index helper for the round-robin arbiter.
package arb_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_OWNED = 2'd1;

  // Next requester index, wrapping n-1 back to 0.
  function automatic int unsigned arb_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin winner select: first set req bit at or after ptr, wrapping.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  always_comb begin
    int unsigned j;
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    j       = 32'(ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_vld && req[j[IDX_W-1:0]]) begin
        win_vld              = 1'b1;
        win_oh[j[IDX_W-1:0]] = 1'b1;
        win_idx              = j[IDX_W-1:0];
      end
      j = arb_wrap_inc(j, N_REQ);
    end
  end

endmodule

// File: rtl/axi_rr_arbiter_n.sv
// N-requester round-robin arbiter with grant lock until release.
// Optional watchdog revoking stuck grants is built when ARB_TIMEOUT_EN is defined.
module axi_rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int IDX_W       = $clog2(N_REQ),
  parameter int TIMEOUT_CYC = 256
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_REQ-1:0] req,
  input  logic             reg_release,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld,
  output logic             timeout
);

  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("axi_rr_arbiter_n: illegal N_REQ or TIMEOUT_CYC");
  end

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_idx;
  logic [N_REQ-1:0] r_grant;
  logic             r_timeout;

  logic             w_to;
  logic             w_rel;
  logic [IDX_W-1:0] w_ptr_adv;
  logic [IDX_W-1:0] w_pick_ptr;
  logic [N_REQ-1:0] w_win_oh;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_win_vld;

  // A release (or watchdog revoke) moves priority past the owner before re-arbitrating.
  assign w_ptr_adv  = IDX_W'(arb_wrap_inc(32'(r_idx), N_REQ));
  assign w_rel      = (r_state == ARB_OWNED) && (reg_release || w_to);
  assign w_pick_ptr = w_rel ? w_ptr_adv : r_ptr;

  arb_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req),
    .ptr     (w_pick_ptr),
    .win_oh  (w_win_oh),
    .win_idx (w_win_idx),
    .win_vld (w_win_vld)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (r_state != ARB_OWNED || w_rel) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_to = (r_state == ARB_OWNED) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_to = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ARB_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_grant   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to;
      case (r_state)
        ARB_IDLE: begin
          if (w_win_vld) begin
            r_grant <= w_win_oh;
            r_idx   <= w_win_idx;
            r_state <= ARB_OWNED;
          end
        end
        ARB_OWNED: begin
          if (w_rel) begin
            r_ptr <= w_ptr_adv;
            if (w_win_vld) begin
              r_grant <= w_win_oh;
              r_idx   <= w_win_idx;
            end else begin
              r_grant <= '0;
              r_idx   <= '0;
              r_state <= ARB_IDLE;
            end
          end
        end
        default: begin
          r_grant <= '0;
          r_idx   <= '0;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign grant_idx = r_idx;
  assign grant_vld = |r_grant;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_axi_rr_arbiter_n.sv
// Directed-vector bench for axi_rr_arbiter_n (N_REQ=4, TIMEOUT_CYC=8); honours ARB_TIMEOUT_EN.
module tb_axi_rr_arbiter_n;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] req = '0;
  logic       reg_release = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_vld;
  logic       timeout;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] rot_exp [6] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  axi_rr_arbiter_n #(
    .N_REQ       (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .req         (req),
    .reg_release (reg_release),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_vld   (grant_vld),
    .timeout     (timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_idx", 32'(grant_idx), 32'h0);
    chk("rst_vld", 32'(grant_vld), 32'h0);
    chk("rst_to", 32'(timeout), 32'h0);
    RST_N = 1'b1;
    tick();

    // Test 1: first grant one cycle after req, back-to-back handover on release
    req = 4'b0101;
    tick();
    chk("t1_grant0", 32'(grant), 32'h1);
    chk("t1_vld", 32'(grant_vld), 32'h1);
    reg_release = 1'b1;
    tick();
    reg_release = 1'b0;
    chk("t1_grant2", 32'(grant), 32'h4);
    chk("t1_idx2", 32'(grant_idx), 32'h2);

    // Test 2: all requesting, rotation with wrap
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      reg_release = 1'b1;
      tick();
      reg_release = 1'b0;
      chk("t2_rot", 32'(grant), 32'(rot_exp[i]));
      tick();
      tick();
      chk("t2_hold", 32'(grant), 32'(rot_exp[i]));
    end

    // Test 3: owner 2 drops req, no release, grant locked
    req = 4'b0100;
    reg_release = 1'b1;
    tick();
    reg_release = 1'b0;
    chk("t3_own2", 32'(grant), 32'h4);
    req = 4'b0000;
    for (int i = 0; i < 20; i++) tick();
    chk("t3_lock", 32'(grant), 32'h4);
    chk("t3_lock_idx", 32'(grant_idx), 32'h2);

    // Test 4: sole requester re-granted; req=0 at release -> IDLE
    req = 4'b0010;
    reg_release = 1'b1;
    tick();
    chk("t4_to1", 32'(grant), 32'h2);
    tick();
    chk("t4_sole", 32'(grant), 32'h2);
    req = 4'b0000;
    tick();
    chk("t4_drop", 32'(grant), 32'h0);
    chk("t4_drop_vld", 32'(grant_vld), 32'h0);
    tick();
    tick();
    reg_release = 1'b0;
    req = 4'b1011;
    tick();
    chk("t4_idle_ptr", 32'(grant), 32'h8);
    chk("t4_idle_idx", 32'(grant_idx), 32'h3);
    // req rising with release is eligible
    req = 4'b0001;
    reg_release = 1'b1;
    tick();
    chk("t4_simul", 32'(grant), 32'h1);
    req = 4'b0010;
    tick();
    chk("t4_g1", 32'(grant), 32'h2);
    req = 4'b1111;
    tick();
    reg_release = 1'b0;
    chk("t4_g2", 32'(grant), 32'h4);

    // Test 5: async reset mid-cycle while owned, ptr restarts at 0
    #3;
    RST_N = 1'b0;
    #1;
    chk("t5_async_grant", 32'(grant), 32'h0);
    chk("t5_async_vld", 32'(grant_vld), 32'h0);
    chk("t5_async_idx", 32'(grant_idx), 32'h0);
    tick();
    RST_N = 1'b1;
    req = 4'b1010;
    tick();
    chk("t5_ptr0", 32'(grant), 32'h2);
    req = 4'b1000;
    reg_release = 1'b1;
    tick();
    reg_release = 1'b0;
    chk("t5_g3", 32'(grant), 32'h8);

    // Test 6: watchdog (or indefinite hold without it)
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    req = 4'b0011;
    tick();
    chk("t6_g0", 32'(grant), 32'h1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t6_pre_grant", 32'(grant), 32'h1);
      chk("t6_pre_to", 32'(timeout), 32'h0);
    end
    tick();
`ifdef ARB_TIMEOUT_EN
    chk("t6_to_grant", 32'(grant), 32'h2);
    chk("t6_to_pulse", 32'(timeout), 32'h1);
    tick();
    chk("t6_to_clear", 32'(timeout), 32'h0);
    chk("t6_to_hold", 32'(grant), 32'h2);
`else
    chk("t6_hold_grant", 32'(grant), 32'h1);
    chk("t6_hold_to", 32'(timeout), 32'h0);
    for (int i = 0; i < 40; i++) tick();
    chk("t6_hold_long", 32'(grant), 32'h1);
    chk("t6_hold_long_to", 32'(timeout), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
